// File: rtl/acoustic_burst_gen.sv
// Multi-channel square-wave burst generator with per-channel start delay.
// IDLE -> BURST -> GAP, free-running or triggered single shot.
module acoustic_burst_gen #(
    parameter int N_CH     = 4,
    parameter int HALF_W   = 16,
    parameter int BURST_W  = 16,
    parameter int PERIOD_W = 28,
    parameter int DELAY_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      mode,
    input  logic                      trigger,
    input  logic [HALF_W-1:0]         half_period,
    input  logic [BURST_W-1:0]        burst_cycles,
    input  logic [PERIOD_W-1:0]       repeat_period,
    input  logic [N_CH*DELAY_W-1:0]   ch_delay,
    input  logic [N_CH-1:0]           ch_mask,
    output logic [N_CH-1:0]           signal,
    output logic                      busy,
    output logic                      burst_start,
    output logic                      burst_done
);

    localparam int HB_W = HALF_W + BURST_W + 1;
    localparam int L_W  = ((HB_W > DELAY_W) ? HB_W : DELAY_W) + 1;
    localparam int T_W  = ((PERIOD_W > L_W) ? PERIOD_W : L_W) + 1;
    localparam int PH_W = HALF_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

    state_t                          state_q, state_d;
    logic [T_W-1:0]                  t_q, t_d;
    logic [HALF_W-1:0]               h_q, h_d;
    logic [PERIOD_W-1:0]             p_q, p_d;
    logic [N_CH-1:0][DELAY_W-1:0]    dly_q, dly_d;
    logic [N_CH-1:0]                 mask_q, mask_d;
    logic [HB_W-1:0]                 len_q, len_d;
    logic [L_W-1:0]                  last_q, last_d;
    logic [N_CH-1:0][PH_W-1:0]       ph_q, ph_d;
    logic [N_CH-1:0]                 signal_q, signal_d;
    logic                            busy_q, busy_d;
    logic                            start_q, start_d;
    logic                            done_q, done_d;

    logic [HALF_W-1:0]               h_in;
    logic [HB_W-2:0]                 prod_in;
    logic [HB_W-1:0]                 len_in;
    logic [DELAY_W-1:0]              dmax_in;
    logic [L_W-1:0]                  last_in;
    logic [T_W:0]                    t_ext;
    logic [T_W-1:0]                  rel;
    logic [PH_W-1:0]                 per_m1;
    logic                            latch;

    // Burst geometry from the live inputs, captured only when a burst is launched.
    always_comb begin
        h_in    = (half_period == '0) ? HALF_W'(1) : half_period;
        prod_in = (HB_W-1)'(h_in) * (HB_W-1)'(burst_cycles);
        len_in  = {prod_in, 1'b0};
        dmax_in = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch_mask[i] && (ch_delay[i*DELAY_W +: DELAY_W] > dmax_in))
                dmax_in = ch_delay[i*DELAY_W +: DELAY_W];
        end
        if ((burst_cycles == '0) || (ch_mask == '0))
            last_in = '0;
        else
            last_in = L_W'(dmax_in) + L_W'(len_in);
    end

    always_comb begin
        state_d  = state_q;
        t_d      = (&t_q) ? t_q : t_q + T_W'(1);
        t_ext    = {1'b0, t_q};
        latch    = 1'b0;
        done_d   = 1'b0;
        signal_d = '0;
        ph_d     = ph_q;
        rel      = '0;
        per_m1   = {h_q, 1'b0} - PH_W'(1);

        unique case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (enable && (!mode || trigger)) begin
                    state_d = S_BURST;
                    latch   = 1'b1;
                end
            end
            S_BURST: begin
                // ph tracks (t - D_i) mod 2H; signal is registered, giving u = t-1-D_i.
                for (int unsigned i = 0; i < N_CH; i++) begin
                    if (t_q >= T_W'(dly_q[i])) begin
                        rel         = t_q - T_W'(dly_q[i]);
                        signal_d[i] = mask_q[i] && (rel < T_W'(len_q)) && (ph_q[i] < PH_W'(h_q));
                        ph_d[i]     = (ph_q[i] == per_m1) ? '0 : ph_q[i] + PH_W'(1);
                    end
                end
                if (t_q >= T_W'(last_q)) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (!mode) begin
                    if ((t_ext + (T_W+1)'(1)) >= (T_W+1)'(p_q)) begin
                        state_d = enable ? S_BURST : S_IDLE;
                        latch   = enable;
                        t_d     = '0;
                    end
                end else if ((t_ext + (T_W+1)'(2)) >= (T_W+1)'(p_q)) begin
                    state_d = S_IDLE;
                    t_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (latch) begin
            t_d  = '0;
            ph_d = '0;
        end
        h_d     = latch ? h_in          : h_q;
        p_d     = latch ? repeat_period : p_q;
        dly_d   = latch ? ch_delay      : dly_q;
        mask_d  = latch ? ch_mask       : mask_q;
        len_d   = latch ? len_in        : len_q;
        last_d  = latch ? last_in       : last_q;
        start_d = latch;
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            h_q      <= '0;
            p_q      <= '0;
            dly_q    <= '0;
            mask_q   <= '0;
            len_q    <= '0;
            last_q   <= '0;
            ph_q     <= '0;
            signal_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            h_q      <= h_d;
            p_q      <= p_d;
            dly_q    <= dly_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            last_q   <= last_d;
            ph_q     <= ph_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign signal      = signal_q;
    assign busy        = busy_q;
    assign burst_start = start_q;
    assign burst_done  = done_q;

endmodule

// File: tb/tb_acoustic_burst_gen.sv
// Scoreboard bench for acoustic_burst_gen: a cycle model derived from the burst
// timing equations predicts every output cycle.
module tb_acoustic_burst_gen;

    localparam int N_CH = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable, mode, trigger;
    logic [15:0]        half_period, burst_cycles;
    logic [27:0]        repeat_period;
    logic [63:0]        ch_delay;
    logic [3:0]         ch_mask;
    logic [3:0]         signal;
    logic               busy, burst_start, burst_done;

    acoustic_burst_gen #(
        .N_CH(4), .HALF_W(16), .BURST_W(16), .PERIOD_W(28), .DELAY_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .trigger(trigger),
        .half_period(half_period), .burst_cycles(burst_cycles),
        .repeat_period(repeat_period), .ch_delay(ch_delay), .ch_mask(ch_mask),
        .signal(signal), .busy(busy), .burst_start(burst_start), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] sb_q[$];

    // model state: 0 idle, 1 burst, 2 gap; mt = cycles since burst_start
    int     ms = 0;
    longint mt = 0;
    longint mH, mB, mP, mL;
    longint md[N_CH];
    logic [3:0] mmask;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_latch();
        longint dmax;
        mH    = (half_period == 0) ? 1 : longint'(half_period);
        mB    = longint'(burst_cycles);
        mP    = longint'(repeat_period);
        mmask = ch_mask;
        dmax  = 0;
        for (int i = 0; i < N_CH; i++) begin
            md[i] = longint'(ch_delay[i*16 +: 16]);
            if (mmask[i] && md[i] > dmax) dmax = md[i];
        end
        mL = (mB == 0 || mmask == 0) ? 0 : dmax + 2 * mH * mB;
    endtask

    task automatic model_step();
        longint nt;
        if (!rst_n) begin
            ms = 0; mt = 0;
        end else begin
            case (ms)
                0: if (enable && (!mode || trigger)) begin
                    model_latch(); ms = 1; mt = 0;
                end
                1: begin
                    if (mt == mL) ms = 2;
                    mt++;
                end
                default: begin
                    nt = mt + 1;
                    if (!mode) begin
                        // next start at t = max(P, L+2)
                        if (nt >= mP) begin
                            if (enable) begin model_latch(); ms = 1; end
                            else ms = 0;
                            mt = 0;
                        end else mt = nt;
                    end else begin
                        if (nt >= mP - 1) begin ms = 0; mt = 0; end
                        else mt = nt;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] s;
        longint u;
        s = '0;
        if (ms == 1) begin
            for (int i = 0; i < N_CH; i++) begin
                u = mt - 1 - md[i];
                if (mmask[i] && u >= 0 && u < 2 * mH * mB && (u % (2 * mH)) < mH)
                    s[i] = 1'b1;
            end
        end
        return {s, ms != 0, (ms == 1 && mt == 0), (ms == 2 && mt == mL + 1)};
    endfunction

    task automatic step(input int n);
        logic [6:0] e;
        repeat (n) begin
            model_step();
            sb_q.push_back(model_out());
            @(negedge clk);
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 8'd1, 8'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("signal", {4'b0, signal}, {4'b0, e[6:3]});
                check_eq("busy",   {7'b0, busy},        {7'b0, e[2]});
                check_eq("start",  {7'b0, burst_start}, {7'b0, e[1]});
                check_eq("done",   {7'b0, burst_done},  {7'b0, e[0]});
            end
        end
    endtask

    task automatic set_cfg(input int h, input int b, input int p,
                           input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] m);
        half_period   = 16'(h);
        burst_cycles  = 16'(b);
        repeat_period = 28'(p);
        ch_delay      = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        ch_mask       = m;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 1'b0; trigger = 1'b0;
        set_cfg(3, 2, 40, 0, 2, 5, 0, 4'b1011);
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        step(2);

        // free-run, mid-burst config change must not disturb the running burst
        enable = 1'b1;
        step(6);
        half_period = 16'd7; burst_cycles = 16'd1;
        step(80);
        enable = 1'b0;
        step(60);

        // short period, channel 2 (D=5) enabled: back-to-back bursts
        set_cfg(3, 2, 10, 0, 2, 5, 0, 4'b1111);
        enable = 1'b1;
        step(60);
        enable = 1'b0;
        step(40);

        // triggers with enable low are ignored
        mode = 1'b1;
        set_cfg(3, 2, 50, 0, 2, 5, 0, 4'b1011);
        trigger = 1'b1; step(1); trigger = 1'b0; step(3);

        // triggered single shot with ignored triggers during burst and hold-off
        enable = 1'b1;
        for (int k = 0; k < 80; k++) begin
            trigger = (k == 0 || k == 10 || k == 30 || k == 55);
            step(1);
        end
        trigger = 1'b0;
        step(60);
        enable = 1'b0; mode = 1'b0;
        step(10);

        // edge configs: B=0, H=0, mask=0
        set_cfg(3, 0, 8, 1, 0, 0, 0, 4'b1111);
        enable = 1'b1;
        step(20);
        set_cfg(0, 2, 8, 1, 0, 3, 0, 4'b0101);
        step(30);
        set_cfg(2, 3, 8, 0, 0, 0, 0, 4'b0000);
        step(20);
        enable = 1'b0;
        step(20);

        // asynchronous reset mid-burst
        set_cfg(3, 2, 40, 0, 2, 5, 0, 4'b1111);
        enable = 1'b1;
        step(3);
        rst_n = 1'b0;
        #1;
        check_eq("rst_signal", {4'b0, signal}, 8'd0);
        check_eq("rst_busy",   {7'b0, busy},   8'd0);
        check_eq("rst_start",  {7'b0, burst_start}, 8'd0);
        check_eq("rst_done",   {7'b0, burst_done},  8'd0);
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        step(10);
        enable = 1'b0;
        step(60);

        // enable dropped mid-burst: burst completes, no restart
        set_cfg(3, 2, 30, 0, 2, 5, 0, 4'b1011);
        enable = 1'b1;
        step(5);
        enable = 1'b0;
        step(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
